// File: rtl/dnn_accel_pio_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ Avalon-MM masters onto one PIO-style slave.
// Each transfer takes three states: IDLE (arbitrate), ISSUE (strobe) and RESP (waitrequest low).
module dnn_accel_pio_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 2,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_address,
  input  logic [NUM_REQ*DW-1:0] req_writedata,
  output logic [NUM_REQ-1:0]    req_waitrequest,
  output logic [DW-1:0]         req_readdata,
  output logic                  slv_chipselect,
  output logic                  slv_write_n,
  output logic [AW-1:0]         slv_address,
  output logic [DW-1:0]         slv_writedata,
  input  logic [DW-1:0]         slv_readdata,
  output logic [2:0]            grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 is_write_r;
  logic                 is_write_nxt_s;
  logic [2:0]           grant_nxt_s;
  logic [2:0]           win_s;
  logic [NUM_REQ-1:0]   any_req_s;
  logic [AW-1:0]        win_addr_s;
  logic [DW-1:0]        win_wdata_s;
  logic                 win_is_write_s;
  logic [AW-1:0]        addr_nxt_s;
  logic [DW-1:0]        wdata_nxt_s;
  logic [DW-1:0]        rdata_nxt_s;
  logic                 cs_nxt_s;
  logic                 write_n_nxt_s;
  logic [NUM_REQ-1:0]   wait_nxt_s;
  logic                 busy_nxt_s;

  // First requester found when searching last+1, last+2, ... modulo NUM_REQ.
  function automatic logic [2:0] pick_winner(input logic [NUM_REQ-1:0] reqs,
                                             input logic [2:0]         last);
    logic [2:0] winner;
    logic       found;
    logic [3:0] idx;
    winner = last;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last} + 4'(k);
      if (idx >= 4'(NUM_REQ)) begin
        idx = idx - 4'(NUM_REQ);
      end else begin
        idx = idx;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && reqs[j] && (idx == 4'(j))) begin
          winner = 3'(j);
          found  = 1'b1;
        end else begin
          winner = winner;
        end
      end
    end
    return winner;
  endfunction

  assign any_req_s = req_read | req_write;
  assign win_s     = pick_winner(any_req_s, grant_id);

  // Demultiplex the winning requester's address, data and direction.
  always_comb begin
    win_addr_s     = {AW{1'b0}};
    win_wdata_s    = {DW{1'b0}};
    win_is_write_s = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_s == 3'(j)) begin
        win_addr_s     = req_address[j*AW +: AW];
        win_wdata_s    = req_writedata[j*DW +: DW];
        win_is_write_s = req_write[j];
      end else begin
        win_is_write_s = win_is_write_s;
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = grant_id;
    addr_nxt_s     = slv_address;
    wdata_nxt_s    = slv_writedata;
    is_write_nxt_s = is_write_r;
    rdata_nxt_s    = req_readdata;
    cs_nxt_s       = 1'b0;
    write_n_nxt_s  = 1'b1;
    wait_nxt_s     = {NUM_REQ{1'b1}};
    busy_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (|any_req_s) begin
          state_nxt_s    = ISSUE;
          grant_nxt_s    = win_s;
          addr_nxt_s     = win_addr_s;
          wdata_nxt_s    = win_wdata_s;
          is_write_nxt_s = win_is_write_s;
          cs_nxt_s       = 1'b1;
          write_n_nxt_s  = ~win_is_write_s;
          busy_nxt_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = RESP;
        busy_nxt_s  = 1'b1;
        if (!is_write_r) begin
          rdata_nxt_s = slv_readdata;
        end else begin
          rdata_nxt_s = req_readdata;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
          wait_nxt_s[j] = (grant_id != 3'(j));
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers; an asynchronous reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      grant_id        <= 3'(NUM_REQ - 1);
      is_write_r      <= 1'b0;
      slv_address     <= {AW{1'b0}};
      slv_writedata   <= {DW{1'b0}};
      slv_chipselect  <= 1'b0;
      slv_write_n     <= 1'b1;
      req_readdata    <= {DW{1'b0}};
      req_waitrequest <= {NUM_REQ{1'b1}};
      busy            <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      grant_id        <= grant_nxt_s;
      is_write_r      <= is_write_nxt_s;
      slv_address     <= addr_nxt_s;
      slv_writedata   <= wdata_nxt_s;
      slv_chipselect  <= cs_nxt_s;
      slv_write_n     <= write_n_nxt_s;
      req_readdata    <= rdata_nxt_s;
      req_waitrequest <= wait_nxt_s;
      busy            <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_dnn_accel_pio_arbiter.sv
// Directed bench for dnn_accel_pio_arbiter with two requesters and a zero-wait slave model
// that returns 0x7F at address 0 and 0 elsewhere.
module tb_dnn_accel_pio_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 2;
  localparam int DW      = 32;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_read;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*AW-1:0] req_address;
  logic [NUM_REQ*DW-1:0] req_writedata;
  logic [NUM_REQ-1:0]    req_waitrequest;
  logic [DW-1:0]         req_readdata;
  logic                  slv_chipselect;
  logic                  slv_write_n;
  logic [AW-1:0]         slv_address;
  logic [DW-1:0]         slv_writedata;
  logic [DW-1:0]         slv_readdata;
  logic [2:0]            grant_id;
  logic                  busy;

  int n_assert;
  int n_fail;

  dnn_accel_pio_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_address     (req_address),
    .req_writedata   (req_writedata),
    .req_waitrequest (req_waitrequest),
    .req_readdata    (req_readdata),
    .slv_chipselect  (slv_chipselect),
    .slv_write_n     (slv_write_n),
    .slv_address     (slv_address),
    .slv_writedata   (slv_writedata),
    .slv_readdata    (slv_readdata),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  assign slv_readdata = (slv_address == 2'd0) ? 32'h0000_007F : 32'h0000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cs"},    32'(slv_chipselect),  32'd0);
    check_eq({tag, "_wn"},    32'(slv_write_n),     32'd1);
    check_eq({tag, "_addr"},  32'(slv_address),     32'd0);
    check_eq({tag, "_wdata"}, slv_writedata,        32'd0);
    check_eq({tag, "_wait"},  32'(req_waitrequest), 32'h3);
    check_eq({tag, "_rdata"}, req_readdata,         32'd0);
    check_eq({tag, "_grant"}, 32'(grant_id),        32'd1);
    check_eq({tag, "_busy"},  32'(busy),            32'd0);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    req_read      = 2'b00;
    req_write     = 2'b00;
    req_address   = 4'h0;
    req_writedata = 64'h0;
    step();
    step();
    check_reset_values("rst");
    reset_n = 1'b1;
    step();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Test 1: req0 write addr0 data 0x55.
    req_write     = 2'b01;
    req_writedata = {32'h0, 32'h0000_0055};
    step();
    check_eq("t1_cs",    32'(slv_chipselect),  32'd1);
    check_eq("t1_wn",    32'(slv_write_n),     32'd0);
    check_eq("t1_wdata", slv_writedata,        32'h55);
    check_eq("t1_grant", 32'(grant_id),        32'd0);
    check_eq("t1_busy",  32'(busy),            32'd1);
    check_eq("t1_wait_issue", 32'(req_waitrequest), 32'h3);
    req_write = 2'b00;
    step();
    check_eq("t1_cs_resp",   32'(slv_chipselect),  32'd0);
    check_eq("t1_wait_resp", 32'(req_waitrequest), 32'h2);
    check_eq("t1_busy_resp", 32'(busy),            32'd1);
    step();
    check_eq("t1_wait_idle", 32'(req_waitrequest), 32'h3);
    check_eq("t1_busy_idle", 32'(busy),            32'd0);

    // Test 2a: req1 reads addr0 and gets 0x7F.
    req_read    = 2'b10;
    req_address = {2'd0, 2'd0};
    step();
    check_eq("t2_grant", 32'(grant_id),       32'd1);
    check_eq("t2_cs",    32'(slv_chipselect), 32'd1);
    check_eq("t2_wn",    32'(slv_write_n),    32'd1);
    req_read = 2'b00;
    step();
    check_eq("t2_wait", 32'(req_waitrequest), 32'h1);
    check_eq("t2_rdata", req_readdata,        32'h7F);
    step();
    check_eq("t2_rdata_hold", req_readdata, 32'h7F);

    // Test 5: read+write together is a write; readdata must keep 0x7F.
    req_read      = 2'b01;
    req_write     = 2'b01;
    req_address   = {2'd0, 2'd1};
    req_writedata = {32'h0, 32'h0000_0012};
    step();
    check_eq("t5_grant", 32'(grant_id),       32'd0);
    check_eq("t5_wn",    32'(slv_write_n),    32'd0);
    check_eq("t5_addr",  32'(slv_address),    32'd1);
    check_eq("t5_wdata", slv_writedata,       32'h12);
    req_read  = 2'b00;
    req_write = 2'b00;
    step();
    check_eq("t5_wait",  32'(req_waitrequest), 32'h2);
    check_eq("t5_rdata", req_readdata,         32'h7F);
    step();

    // Test 2b: read of a non-zero address returns 0.
    req_read    = 2'b10;
    req_address = {2'd2, 2'd0};
    step();
    check_eq("t2b_addr", 32'(slv_address), 32'd2);
    req_read = 2'b00;
    step();
    check_eq("t2b_rdata", req_readdata, 32'd0);
    step();

    // Test 3: both write continuously after reset; grants alternate 0,1,0,1 every 3 cycles.
    reset_n = 1'b0;
    step();
    reset_n       = 1'b1;
    req_write     = 2'b11;
    req_address   = {2'd3, 2'd1};
    req_writedata = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int t = 0; t < 4; t++) begin
      step();
      check_eq($sformatf("t3_grant%0d", t), 32'(grant_id),       32'(t % 2));
      check_eq($sformatf("t3_cs%0d", t),    32'(slv_chipselect), 32'd1);
      check_eq($sformatf("t3_wdata%0d", t), slv_writedata,
               (t % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0001);
      step();
      check_eq($sformatf("t3_wait%0d", t), 32'(req_waitrequest),
               (t % 2 == 0) ? 32'h2 : 32'h1);
      step();
      check_eq($sformatf("t3_idle%0d", t), 32'(busy), 32'd0);
    end

    // Test 4: reset during ISSUE abandons the write.
    req_write     = 2'b01;
    req_writedata = {32'h0, 32'h0000_0099};
    step();
    check_eq("t4_cs_issue", 32'(slv_chipselect), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values("t4_rst");
    step();
    check_eq("t4_no_resp", 32'(req_waitrequest), 32'h3);
    req_write = 2'b11;
    reset_n   = 1'b1;
    step();
    check_eq("t4_first_grant", 32'(grant_id), 32'd0);
    req_write = 2'b00;
    step();
    step();

    // Test 6: req1 drops its read during ISSUE; transfer still completes.
    req_read    = 2'b10;
    req_address = {2'd3, 2'd0};
    step();
    check_eq("t6_grant", 32'(grant_id), 32'd1);
    req_read = 2'b00;
    step();
    check_eq("t6_wait", 32'(req_waitrequest), 32'h1);
    step();
    check_eq("t6_wait_idle", 32'(req_waitrequest), 32'h3);
    check_eq("t6_busy",      32'(busy),            32'd0);
    step();
    check_eq("t6_stay_idle", 32'(slv_chipselect), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
